// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM time base, generator and register block.
// Widths, FSM state encoding and direction encodings.
package pwm_pkg;

   localparam int CNT_WIDTH   = 16;
   localparam int PRESC_WIDTH = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pwm_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the PWM time base.
// Emits a tick once every prescale+1 cycles; held at zero while cleared.
module pwm_prescaler #(
   parameter int PRESC_WIDTH = pwm_pkg::PRESC_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clear,
   input  logic [PRESC_WIDTH-1:0] i_prescale,
   output logic                   o_tick
);

   localparam logic [PRESC_WIDTH-1:0] ONE = 1;

   logic [PRESC_WIDTH-1:0] r_cnt;

   // >= so that a live shrink of prescale below the count fires at once
   assign o_tick = (r_cnt >= i_prescale);

   // Prescale counter: clear on request/disable or after each tick
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + ONE;
      end
   end

endmodule

// File: rtl/pwm_counter.sv
// PWM time base: prescaled up/down counter with shadowed period.
// Period and direction take effect only at wrap or at IDLE->RUN.
module pwm_counter #(
   parameter int CNT_WIDTH   = pwm_pkg::CNT_WIDTH,
   parameter int PRESC_WIDTH = pwm_pkg::PRESC_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_en,
   input  logic                   i_count_reset,
   input  logic                   i_upnotdown,
   input  logic [CNT_WIDTH-1:0]   i_period,
   input  logic [PRESC_WIDTH-1:0] i_prescale,
   output logic [CNT_WIDTH-1:0]   o_count_val,
   output logic                   o_period_done
);

   import pwm_pkg::*;

   localparam logic [CNT_WIDTH-1:0] ONE = 1;

   pwm_state_t           r_state;
   pwm_state_t           w_state_nxt;
   logic [CNT_WIDTH-1:0] r_count;
   logic [CNT_WIDTH-1:0] r_shadow_period;
   logic                 r_shadow_dir;
   logic                 r_done;
   logic                 w_run;
   logic                 w_clear;
   logic                 w_tick;
   logic                 w_step;
   logic                 w_wrap;

   // Counting only happens while in RUN and still enabled
   assign w_run   = (r_state == ST_RUN) && i_en;
   assign w_clear = i_count_reset || !w_run;
   assign w_step  = w_run && w_tick;

   pwm_prescaler #(
      .PRESC_WIDTH (PRESC_WIDTH)
   ) u_presc (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clear    (w_clear),
      .i_prescale (i_prescale),
      .o_tick     (w_tick)
   );

   // Next state: enable alone moves between IDLE and RUN
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (i_en)  w_state_nxt = ST_RUN;
         ST_RUN:  if (!i_en) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Wrap detect also catches a count left above a smaller new period
   always_comb begin
      w_wrap = 1'b0;
      if (r_shadow_dir == DIR_UP) begin
         w_wrap = (r_count >= r_shadow_period);
      end else begin
         w_wrap = (r_count == '0) || (r_count > r_shadow_period);
      end
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Count, wrap pulse and shadow registers; count_reset overrides all
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count         <= '0;
         r_done          <= 1'b0;
         r_shadow_period <= '0;
         r_shadow_dir    <= DIR_UP;
      end else begin
         r_done <= 1'b0;
         if (i_count_reset) begin
            r_shadow_period <= i_period;
            r_shadow_dir    <= i_upnotdown;
            r_count         <= (i_upnotdown == DIR_UP) ? '0 : i_period;
         end else if ((r_state == ST_IDLE) && i_en) begin
            r_shadow_period <= i_period;
            r_shadow_dir    <= i_upnotdown;
         end else if (w_step) begin
            if (w_wrap) begin
               r_done          <= 1'b1;
               r_shadow_period <= i_period;
               r_shadow_dir    <= i_upnotdown;
               r_count         <= (r_shadow_dir == DIR_UP) ? '0 : i_period;
            end else if (r_shadow_dir == DIR_UP) begin
               r_count <= r_count + ONE;
            end else begin
               r_count <= r_count - ONE;
            end
         end
      end
   end

   assign o_count_val   = r_count;
   assign o_period_done = r_done;

endmodule

// File: doc/pwm_counter.md
Name: pwm_counter

Overview:
- Time base feeding pwm_gen. Produces the free-running count_val that pwm_gen compares against compare1/compare2.
- Supports a programmable prescaler, an up/down direction and a shadowed period that reloads only at wrap, so period writes never glitch a running cycle.
- Emits a one-cycle period_done pulse at every wrap for the register block and interrupt logic.

Parameters:
- CNT_WIDTH, 16, width of period and count_val (matches pwm_gen).
- PRESC_WIDTH, 8, width of the prescale input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  counter enable (the same register bit that drives pwm_en).
- count_reset  input  1  single-cycle synchronous clear request from the register block.
- upnotdown  input  1  direction: 1 = up, 0 = down.
- period  input  CNT_WIDTH  programmed period P; the count spans 0..P, i.e. P+1 states.
- prescale  input  PRESC_WIDTH  count advances once every prescale+1 clk cycles.
- count_val  output  CNT_WIDTH  current count, registered.
- period_done  output  1  one-cycle pulse on wrap, registered.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - count_val=0, period_done=0.
  - Prescaler counter=0, shadow period=0, shadow direction=up.
  - FSM goes to IDLE.
- Priority: rst_n > count_reset > en.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on en=1. In that same edge, load shadow_period<=period and shadow_dir<=upnotdown. The prescaler starts at 0 and count_val is unchanged.
  - RUN -> IDLE on en=0. count_val holds its value, the prescaler clears, period_done=0.
  - A later re-enable resumes from the held count_val. If count_val exceeds the new shadow_period, the next tick wraps (see the wrap rules below).
- Prescaler:
  - tick=1 when presc_cnt==prescale. presc_cnt then returns to 0; otherwise it increments.
  - The prescale value is sampled live. If presc_cnt>prescale after a write, tick fires and presc_cnt clears on the next edge.
  - prescale=0 gives a tick every cycle.
- On a tick in RUN, up direction:
  - If count_val>=shadow_period: count_val<=0, period_done<=1, and shadows reload from period/upnotdown.
  - Otherwise count_val<=count_val+1.
- On a tick in RUN, down direction:
  - If count_val==0 or count_val>shadow_period: count_val<=period (the newly loaded shadow), period_done<=1, and shadows reload.
  - Otherwise count_val<=count_val-1.
- period_done is high exactly in the cycle in which the wrapped count_val is first visible. It is 0 in all other cycles.
- Latency: count_val changes on the clk edge that samples tick=1. It is registered, with no combinational path from any input to any output.
- period=0: count_val stays 0 (up) or reloads 0 (down). period_done pulses on every tick.
- Changes to period or upnotdown mid-cycle take effect only at the next wrap or the next IDLE->RUN transition.
- count_reset=1 (any state):
  - presc_cnt<=0, period_done<=0, and shadows reload.
  - count_val<=0 if upnotdown=1, else count_val<=period.
  - State is unchanged. An en edge occurring in the same cycle still updates state, but the count_reset actions win.
- Arithmetic is unsigned CNT_WIDTH. With period=2^CNT_WIDTH-1, up-count wraps 0xFFFF->0 with no overflow flag.

Decomposition:
- pwm_pkg holds:
  - CNT_WIDTH and PRESC_WIDTH constants.
  - The FSM state encoding (IDLE, RUN).
  - Direction encodings DIR_UP=1 and DIR_DOWN=0, shared with pwm_gen and the register block.
- One sub-module, pwm_prescaler: clk, rst_n, clear, prescale -> tick. It holds presc_cnt and its clear-on-disable logic.
- pwm_counter holds the FSM, the shadow registers and the count/wrap logic.

Test Plan:
1. Up count: en=1, upnotdown=1, period=3, prescale=0 -> count_val 0,1,2,3,0,1... with period_done=1 only in cycles where count_val returns to 0.
2. Prescaled up count: period=2, prescale=2 -> each count value held 3 cycles: 0,0,0,1,1,1,2,2,2,0. period_done is a single cycle at the first 0 after 2.
3. Down count: upnotdown=0, period=2, prescale=0 -> 2,1,0,2,1,0. period_done pulses in each cycle showing the reloaded 2. Down count is entered via count_reset so it starts at 2.
4. Shadowed period: up count, period=5, write period=2 while count_val=1 -> continues 2,3,4,5,0 and then runs 1,2,0. No early wrap.
5. Disable and resume: en low at count_val=3 for 4 cycles -> count_val holds 3 and period_done=0. After en returns high, the next tick gives 4. A count_reset pulse while enabled with upnotdown=1 -> count_val=0 next cycle and the prescaler restarts.
6. Reset mid-run: rst_n=0 for one edge at count_val=7 -> count_val=0, period_done=0, state IDLE. count_val stays 0 until en is sampled 1 again.
